// File: rtl/matrix_window_loader_if.sv
// Handshake/data bundle between the pixel source, the window loader and the matrix index reader.
// The master drives pixels and control; the slave is the loader.
interface matrix_window_loader_if #(
  parameter int MAX_KERNEL = 3
);
  localparam int IDX_W = $clog2(MAX_KERNEL);
  localparam int KS_W  = $clog2(MAX_KERNEL + 1);

  // Valid/ready rule for both channels: a transfer happens on the rising clk edge where
  // valid and ready are both high; valid-side payload is don't-care otherwise.
  logic                                    clear;
  logic                                    start;
  logic [KS_W-1:0]                         k_size;
  logic                                    px_valid;
  logic [7:0]                              px_data;
  logic                                    px_ready;
  logic                                    win_valid;
  logic                                    win_ready;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] window;
  logic [IDX_W-1:0]                        wr_x;
  logic [IDX_W-1:0]                        wr_y;
  logic [1:0]                              state_dbg;

  modport master (
    output clear, start, k_size, px_valid, px_data, win_ready,
    input  px_ready, win_valid, window, wr_x, wr_y, state_dbg
  );

  modport slave (
    input  clear, start, k_size, px_valid, px_data, win_ready,
    output px_ready, win_valid, window, wr_x, wr_y, state_dbg
  );
endinterface

// File: rtl/matrix_window_loader.sv
// Fills a k x k pixel window (window[x][y], row-major, x fastest) from a serial stream and
// hands it to the reader with valid/ready. Optional macro WINDOW_SLIDE_EN enables stride-1 column sliding.
module matrix_window_loader #(
  parameter int MAX_KERNEL = 3
) (
  input logic                    clk,
  input logic                    n_rst,
  matrix_window_loader_if.slave  bus
);
  localparam int IDX_W = $clog2(MAX_KERNEL);
  localparam int KS_W  = $clog2(MAX_KERNEL + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

  state_t                                   state_q, state_d;
  logic [KS_W-1:0]                          k_lat_q, k_sel, k_last;
  logic [IDX_W-1:0]                         wr_x_q, wr_y_q;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] win_q;
  logic                                     accept, at_last, too_big;
`ifdef WINDOW_SLIDE_EN
  logic                                     col_mode_q;
`endif

  // Only widths that can encode values above MAX_KERNEL need the upper clamp.
  if ((1 << KS_W) - 1 > MAX_KERNEL) begin : g_clamp
    assign too_big = (bus.k_size > KS_W'(MAX_KERNEL));
  end else begin : g_no_clamp
    assign too_big = 1'b0;
  end

  always_comb begin
    k_sel = bus.k_size;
    if (bus.k_size == '0 || too_big) k_sel = KS_W'(MAX_KERNEL);
  end

  assign k_last  = k_lat_q - KS_W'(1);
  assign accept  = bus.px_valid && (state_q == FILL);
  // Column-refill mode keeps wr_x at k_last, so one end condition serves both fill styles.
  assign at_last = (KS_W'(wr_x_q) == k_last) && (KS_W'(wr_y_q) == k_last);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = FILL;
        FILL:    if (accept && at_last) state_d = FULL;
        FULL:    if (bus.win_ready) state_d = FILL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_q      <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      k_lat_q    <= KS_W'(MAX_KERNEL);
`ifdef WINDOW_SLIDE_EN
      col_mode_q <= 1'b0;
`endif
    end else if (bus.clear) begin
      win_q      <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
`ifdef WINDOW_SLIDE_EN
      col_mode_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            win_q      <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            k_lat_q    <= k_sel;
`ifdef WINDOW_SLIDE_EN
            col_mode_q <= 1'b0;
`endif
          end
        end
        FILL: begin
          if (accept) begin
            win_q[wr_x_q][wr_y_q] <= bus.px_data;
            // Position freezes on the final beat so FULL reports where the fill ended.
            if (!at_last) begin
`ifdef WINDOW_SLIDE_EN
              if (col_mode_q) begin
                wr_y_q <= wr_y_q + IDX_W'(1);
              end else
`endif
              if (KS_W'(wr_x_q) == k_last) begin
                wr_x_q <= '0;
                wr_y_q <= wr_y_q + IDX_W'(1);
              end else begin
                wr_x_q <= wr_x_q + IDX_W'(1);
              end
            end
          end
        end
        FULL: begin
          if (bus.win_ready) begin
`ifdef WINDOW_SLIDE_EN
            for (int x = 0; x < MAX_KERNEL - 1; x++) begin
              if (KS_W'(x) < k_last) win_q[x] <= win_q[x+1];
            end
            wr_x_q     <= IDX_W'(k_last);
            wr_y_q     <= '0;
            col_mode_q <= 1'b1;
`else
            wr_x_q <= '0;
            wr_y_q <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.px_ready  = (state_q == FILL);
  assign bus.win_valid = (state_q == FULL);
  assign bus.window    = win_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_matrix_window_loader.sv
// Bench for matrix_window_loader: directed scenarios plus randomized windows checked against
// a positional model of the window array.
module tb_matrix_window_loader;
  localparam int MK    = 3;
  localparam int KS_W  = $clog2(MK + 1);
  localparam int IDX_W = $clog2(MK);
`ifdef WINDOW_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_window_loader_if #(.MAX_KERNEL(MK)) bus();
  matrix_window_loader #(.MAX_KERNEL(MK)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  // Reference: expected window plus the in-order stream of accepted pixels awaiting placement.
  logic [MK-1:0][MK-1:0][7:0] exp_w;
  logic [7:0]                 exp_q[$];
  int                         placed;

  function automatic int eff_k(input int k);
    return (k == 0 || k > MK) ? MK : k;
  endfunction

  task automatic model_start();
    exp_w  = '0;
    placed = 0;
    exp_q.delete();
  endtask

  task automatic model_handshake(input int k);
    placed = 0;
    if (SLIDE) for (int x = 0; x < k - 1; x++) exp_w[x] = exp_w[x+1];
  endtask

  task automatic do_start(input int k);
    bus.start  = 1'b1;
    bus.k_size = KS_W'(k);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.k_size = KS_W'($urandom);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic do_handshake(input int delay, input bit noise);
    bus.px_valid = noise;
    bus.px_data  = 8'($urandom);
    repeat (delay) @(negedge clk);
    bus.win_ready = 1'b1;
    @(negedge clk);
    bus.win_ready = 1'b0;
    bus.px_valid  = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) @(negedge clk);
    bus.px_valid = 1'b1;
    bus.px_data  = d;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.px_ready) done = 1'b1;
      @(negedge clk);
    end
    bus.px_valid = 1'b0;
    bus.px_data  = 8'($urandom);
    if (!done) begin
      total++;
      $display("FAIL px_accept_timeout: px_ready stayed 0, required 1");
    end
  endtask

  // col=1 places beats down column k-1, otherwise row-major with x fastest.
  task automatic fill_pixels(input int n, input int k, input bit col, input int base, input int gap_max);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (base != 0) ? 8'(base + i) : 8'($urandom_range(1, 255));
      send_pixel(d, (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
      exp_q.push_back(d);
    end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      if (col) exp_w[k-1][placed] = d;
      else     exp_w[placed % k][placed / k] = d;
      placed++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    total++; if (bus.state_dbg !== 2'd0 || bus.px_ready !== 1'b0 || bus.win_valid !== 1'b0) $display("FAIL reset_ctrl: state=%0d px_ready=%b win_valid=%b required 0/0/0", bus.state_dbg, bus.px_ready, bus.win_valid); else passed++;
    total++; if (bus.window !== '0 || bus.wr_x !== '0 || bus.wr_y !== '0) $display("FAIL reset_data: window=%h wr=%0d,%0d required all 0", bus.window, bus.wr_x, bus.wr_y); else passed++;
    do_start(3);
    model_start();
    fill_pixels(4, 3, 1'b0, 0, 0);
    total++; if (bus.px_ready !== 1'b1 || bus.window !== exp_w) $display("FAIL mid_fill: px_ready=%b window=%h required 1 %h", bus.px_ready, bus.window, exp_w); else passed++;
    #2 n_rst = 1'b0;
    #1;
    total++; if (bus.px_ready !== 1'b0 || bus.win_valid !== 1'b0 || bus.state_dbg !== 2'd0) $display("FAIL async_reset_ctrl: px_ready=%b win_valid=%b state=%0d required 0/0/0", bus.px_ready, bus.win_valid, bus.state_dbg); else passed++;
    total++; if (bus.window !== '0 || bus.wr_x !== '0 || bus.wr_y !== '0) $display("FAIL async_reset_data: window=%h wr=%0d,%0d required all 0", bus.window, bus.wr_x, bus.wr_y); else passed++;
    @(negedge clk);
    n_rst = 1'b1;
    model_start();
  endtask

  task automatic test_fill();
    int c0;
    do_start(3);
    model_start();
    c0 = cyc;
    fill_pixels(8, 3, 1'b0, 1, 0);
    total++; if (bus.win_valid !== 1'b0 || bus.px_ready !== 1'b1) $display("FAIL fill_before_last: win_valid=%b px_ready=%b required 0/1", bus.win_valid, bus.px_ready); else passed++;
    fill_pixels(1, 3, 1'b0, 9, 0);
    total++; if (bus.win_valid !== 1'b1 || bus.px_ready !== 1'b0) $display("FAIL fill_full: win_valid=%b px_ready=%b required 1/0", bus.win_valid, bus.px_ready); else passed++;
    total++; if (cyc - c0 !== 9) $display("FAIL fill_back_to_back: cycles=%0d required 9", cyc - c0); else passed++;
    total++; if (bus.window !== exp_w) $display("FAIL fill_window: got %h required %h", bus.window, exp_w); else passed++;
    total++; if (bus.window[0][0] !== 8'd1 || bus.window[2][0] !== 8'd3 || bus.window[0][1] !== 8'd4 || bus.window[1][1] !== 8'd5 || bus.window[2][2] !== 8'd9)
      $display("FAIL fill_spots: [0][0]=%0d [2][0]=%0d [0][1]=%0d [1][1]=%0d [2][2]=%0d required 1 3 4 5 9", bus.window[0][0], bus.window[2][0], bus.window[0][1], bus.window[1][1], bus.window[2][2]); else passed++;
  endtask

  task automatic test_hold();
    int ready_seen;
    ready_seen = 0;
    bus.px_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.px_data = 8'($urandom);
      @(negedge clk);
      if (bus.px_ready) ready_seen++;
    end
    total++; if (ready_seen !== 0 || bus.win_valid !== 1'b1) $display("FAIL hold_ready: px_ready cycles=%0d win_valid=%b required 0/1", ready_seen, bus.win_valid); else passed++;
    total++; if (bus.window !== exp_w || bus.wr_x !== IDX_W'(2) || bus.wr_y !== IDX_W'(2)) $display("FAIL hold_frozen: window=%h wr=%0d,%0d required %h 2,2", bus.window, bus.wr_x, bus.wr_y, exp_w); else passed++;
    bus.win_ready = 1'b1;
    @(negedge clk);
    bus.win_ready = 1'b0;
    bus.px_valid  = 1'b0;
    model_handshake(3);
    total++; if (bus.px_ready !== 1'b1 || bus.win_valid !== 1'b0 || bus.state_dbg !== 2'd1) $display("FAIL hold_release: px_ready=%b win_valid=%b state=%0d required 1/0/1", bus.px_ready, bus.win_valid, bus.state_dbg); else passed++;
    total++; if (bus.wr_x !== IDX_W'(SLIDE ? 2 : 0) || bus.wr_y !== '0) $display("FAIL hold_wr_pos: wr=%0d,%0d required %0d,0", bus.wr_x, bus.wr_y, SLIDE ? 2 : 0); else passed++;
  endtask

  task automatic test_refill();
`ifdef WINDOW_SLIDE_EN
    fill_pixels(3, 3, 1'b1, 10, 0);
    total++; if (bus.win_valid !== 1'b1) $display("FAIL slide_full: win_valid=%b required 1", bus.win_valid); else passed++;
    total++; if (bus.window !== exp_w) $display("FAIL slide_window: got %h required %h", bus.window, exp_w); else passed++;
    total++; if (bus.window[0][0] !== 8'd2 || bus.window[0][1] !== 8'd5 || bus.window[0][2] !== 8'd8) $display("FAIL slide_col0: %0d %0d %0d required 2 5 8", bus.window[0][0], bus.window[0][1], bus.window[0][2]); else passed++;
    total++; if (bus.window[1][0] !== 8'd3 || bus.window[1][1] !== 8'd6 || bus.window[1][2] !== 8'd9) $display("FAIL slide_col1: %0d %0d %0d required 3 6 9", bus.window[1][0], bus.window[1][1], bus.window[1][2]); else passed++;
    total++; if (bus.window[2][0] !== 8'd10 || bus.window[2][1] !== 8'd11 || bus.window[2][2] !== 8'd12) $display("FAIL slide_col2: %0d %0d %0d required 10 11 12", bus.window[2][0], bus.window[2][1], bus.window[2][2]); else passed++;
`else
    fill_pixels(3, 3, 1'b0, 10, 0);
    total++; if (bus.win_valid !== 1'b0) $display("FAIL refill_early: win_valid=%b required 0", bus.win_valid); else passed++;
    total++; if (bus.window[2][0] !== 8'd12 || bus.window[0][1] !== 8'd4) $display("FAIL refill_partial: [2][0]=%0d [0][1]=%0d required 12 4", bus.window[2][0], bus.window[0][1]); else passed++;
    fill_pixels(6, 3, 1'b0, 13, 0);
    total++; if (bus.win_valid !== 1'b1) $display("FAIL refill_full: win_valid=%b required 1", bus.win_valid); else passed++;
    total++; if (bus.window !== exp_w) $display("FAIL refill_window: got %h required %h", bus.window, exp_w); else passed++;
`endif
  endtask

  task automatic test_clear();
    do_start(2);
    total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w || bus.wr_x !== IDX_W'(2) || bus.wr_y !== IDX_W'(2)) $display("FAIL start_in_full: win_valid=%b window=%h wr=%0d,%0d required 1 %h 2,2", bus.win_valid, bus.window, bus.wr_x, bus.wr_y, exp_w); else passed++;
    do_clear();
    model_start();
    total++; if (bus.state_dbg !== 2'd0 || bus.win_valid !== 1'b0 || bus.px_ready !== 1'b0 || bus.window !== '0) $display("FAIL clear_full: state=%0d win_valid=%b px_ready=%b window=%h required 0/0/0/0", bus.state_dbg, bus.win_valid, bus.px_ready, bus.window); else passed++;
    do_start(3);
    fill_pixels(4, 3, 1'b0, 0, 2);
    bus.px_valid = 1'b1;
    bus.px_data  = 8'hAA;
    do_clear();
    bus.px_valid = 1'b0;
    model_start();
    total++; if (bus.state_dbg !== 2'd0 || bus.px_ready !== 1'b0 || bus.window !== '0 || bus.wr_x !== '0 || bus.wr_y !== '0) $display("FAIL clear_fill: state=%0d px_ready=%b window=%h wr=%0d,%0d required 0/0/0/0,0", bus.state_dbg, bus.px_ready, bus.window, bus.wr_x, bus.wr_y); else passed++;
    do_start(3);
    total++; if (bus.px_ready !== 1'b1 || bus.wr_x !== '0 || bus.wr_y !== '0) $display("FAIL restart: px_ready=%b wr=%0d,%0d required 1 0,0", bus.px_ready, bus.wr_x, bus.wr_y); else passed++;
    fill_pixels(1, 3, 1'b0, 0, 0);
    total++; if (bus.window !== exp_w || bus.wr_x !== IDX_W'(1)) $display("FAIL restart_first: window=%h wr_x=%0d required %h 1", bus.window, bus.wr_x, exp_w); else passed++;
  endtask

  task automatic test_small_kernel();
    do_clear();
    do_start(2);
    model_start();
    fill_pixels(4, 2, 1'b0, 7, 0);
    total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL k2_window: win_valid=%b window=%h required 1 %h", bus.win_valid, bus.window, exp_w); else passed++;
    total++; if (bus.window[0][0] !== 8'd7 || bus.window[1][0] !== 8'd8 || bus.window[0][1] !== 8'd9 || bus.window[1][1] !== 8'd10) $display("FAIL k2_spots: %0d %0d %0d %0d required 7 8 9 10", bus.window[0][0], bus.window[1][0], bus.window[0][1], bus.window[1][1]); else passed++;
    total++; if (bus.window[2] !== '0 || bus.window[0][2] !== 8'd0 || bus.window[1][2] !== 8'd0) $display("FAIL k2_outside: window=%h required 0 outside 2x2", bus.window); else passed++;
    do_handshake(1, 1'b1);
    model_handshake(2);
    fill_pixels(SLIDE ? 2 : 4, 2, SLIDE, 0, 1);
    total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL k2_second: win_valid=%b window=%h required 1 %h", bus.win_valid, bus.window, exp_w); else passed++;
    do_clear();
    do_start(0);
    model_start();
    fill_pixels(8, 3, 1'b0, 0, 0);
    total++; if (bus.win_valid !== 1'b0) $display("FAIL k0_early: win_valid=%b required 0", bus.win_valid); else passed++;
    fill_pixels(1, 3, 1'b0, 0, 0);
    total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL k0_full: win_valid=%b window=%h required 1 %h", bus.win_valid, bus.window, exp_w); else passed++;
    do_clear();
    do_start(1);
    model_start();
    fill_pixels(1, 1, 1'b0, 0, 0);
    total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL k1_full: win_valid=%b window=%h required 1 %h", bus.win_valid, bus.window, exp_w); else passed++;
  endtask

  task automatic test_random();
    int ks, k;
    for (int r = 0; r < 6; r++) begin
      do_clear();
      ks = $urandom_range(0, 3);
      k  = eff_k(ks);
      do_start(ks);
      model_start();
      fill_pixels(k * k, k, 1'b0, 0, 3);
      total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL rand_first r=%0d k=%0d: win_valid=%b window=%h required 1 %h", r, k, bus.win_valid, bus.window, exp_w); else passed++;
      for (int w = 0; w < 2; w++) begin
        do_handshake($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        model_handshake(k);
        fill_pixels(SLIDE ? k : k * k, k, SLIDE, 0, 3);
        total++; if (bus.win_valid !== 1'b1 || bus.window !== exp_w) $display("FAIL rand_next r=%0d w=%0d k=%0d: win_valid=%b window=%h required 1 %h", r, w, k, bus.win_valid, bus.window, exp_w); else passed++;
      end
    end
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.start     = 1'b0;
    bus.k_size    = '0;
    bus.px_valid  = 1'b0;
    bus.px_data   = '0;
    bus.win_ready = 1'b0;
    model_start();
    test_reset();
    test_fill();
    test_hold();
    test_refill();
    test_clear();
    test_small_kernel();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
